// File: rtl/collector_pkg.sv
// rtl/collector_pkg.sv - shared widths and types for the result collector
package collector_pkg;

    localparam int DEF_ITEM_WIDTH = 8;
    localparam int DEF_SUM_WIDTH  = 16;

    typedef logic [DEF_ITEM_WIDTH-1:0] item_t;
    typedef logic [DEF_SUM_WIDTH-1:0]  sum_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through FIFO over a registered array
module sync_fifo #(
    parameter int  DEPTH  = 16,
    parameter type data_t = collector_pkg::item_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  data_t                  wr_data,
    output data_t                  rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    data_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage array: written only on an accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);

endmodule

// File: rtl/result_collector.sv
// rtl/result_collector.sv - buffers bfm results and frames them into checksummed batches
module result_collector
    import collector_pkg::*;
#(
    parameter int NUM        = 100,
    parameter int ITEM_WIDTH = DEF_ITEM_WIDTH,
    parameter int DEPTH      = 16,
    parameter int SUM_WIDTH  = DEF_SUM_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [ITEM_WIDTH-1:0]    res_i,
    input  logic                     res_valid_i,
    output logic [ITEM_WIDTH-1:0]    m_data_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic                     m_last_o,
    output logic [SUM_WIDTH-1:0]     batch_sum_o,
    output logic                     batch_done_o,
    output logic                     overflow_o,
    input  logic                     clear_i,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int CW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM - 1);

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic [CW-1:0]        cnt;
    logic [SUM_WIDTH-1:0] acc;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign pop       = m_valid_o && m_ready_i;
    assign push      = res_valid_i && (!full || pop);
    assign drop      = res_valid_i && full && !pop;
    assign m_valid_o = !empty;
    assign m_last_o  = m_valid_o && (cnt == LAST_CNT);

    sync_fifo #(
        .DEPTH  (DEPTH),
        .data_t (logic [ITEM_WIDTH-1:0])
    ) u_fifo (
        .clk     (clk_i),
        .rst_n   (reset_i),
        .push    (push),
        .pop     (pop),
        .wr_data (res_i),
        .rd_data (m_data_o),
        .full    (full),
        .empty   (empty),
        .level   (level_o)
    );

    // Batch framing: count and sum popped beats, publish on the last one
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt          <= '0;
            acc          <= '0;
            batch_sum_o  <= '0;
            batch_done_o <= 1'b0;
        end else if (pop) begin
            if (m_last_o) begin
                cnt          <= '0;
                acc          <= '0;
                batch_sum_o  <= acc + SUM_WIDTH'(m_data_o);
                batch_done_o <= !batch_done_o;
            end else begin
                cnt <= cnt + CW'(1);
                acc <= acc + SUM_WIDTH'(m_data_o);
            end
        end
    end

    // Sticky drop flag; a new drop wins over a same-cycle clear
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end else if (clear_i) begin
            overflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - table-driven and sequence checks for result_collector
module tb_result_collector;

    logic        clk;
    logic        reset_i;

    logic [7:0]  res;
    logic        res_valid;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [15:0] batch_sum;
    logic        batch_done;
    logic        overflow;
    logic        clear;
    logic [4:0]  level;

    logic [7:0]  b_res;
    logic        b_res_valid;
    logic [7:0]  b_data;
    logic        b_valid;
    logic        b_ready;
    logic        b_last;
    logic [7:0]  b_sum;
    logic        b_done;
    logic        b_overflow;
    logic        b_clear;
    logic [4:0]  b_level;

    int n_assert = 0;
    int n_fail   = 0;

    result_collector #(.NUM(4), .ITEM_WIDTH(8), .DEPTH(16), .SUM_WIDTH(16)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .res_i        (res),
        .res_valid_i  (res_valid),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_last_o     (m_last),
        .batch_sum_o  (batch_sum),
        .batch_done_o (batch_done),
        .overflow_o   (overflow),
        .clear_i      (clear),
        .level_o      (level)
    );

    result_collector #(.NUM(2), .ITEM_WIDTH(8), .DEPTH(16), .SUM_WIDTH(8)) dut_b (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .res_i        (b_res),
        .res_valid_i  (b_res_valid),
        .m_data_o     (b_data),
        .m_valid_o    (b_valid),
        .m_ready_i    (b_ready),
        .m_last_o     (b_last),
        .batch_sum_o  (b_sum),
        .batch_done_o (b_done),
        .overflow_o   (b_overflow),
        .clear_i      (b_clear),
        .level_o      (b_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [7:0]  res;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [7:0]  ed;
        logic        el;
        logic [4:0]  elev;
        logic [15:0] esum;
        logic        edone;
        logic        eovf;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rv, input logic [7:0] d, input logic rdy, input logic clr);
        @(negedge clk);
        res_valid = rv;
        res       = d;
        m_ready   = rdy;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic rv, input logic [7:0] d, input logic rdy, input logic clr);
        @(negedge clk);
        b_res_valid = rv;
        b_res       = d;
        b_ready     = rdy;
        b_clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"},   32'(m_valid), 0);
        chk({tag, " last"},    32'(m_last), 0);
        chk({tag, " level"},   32'(level), 0);
        chk({tag, " sum"},     32'(batch_sum), 0);
        chk({tag, " done"},    32'(batch_done), 0);
        chk({tag, " ovf"},     32'(overflow), 0);
        chk({tag, " b_valid"}, 32'(b_valid), 0);
        chk({tag, " b_level"}, 32'(b_level), 0);
        chk({tag, " b_sum"},   32'(b_sum), 0);
        chk({tag, " b_done"},  32'(b_done), 0);
    endtask

    initial begin
        //            rv  res    rdy clr  ev  ed     el  lev  sum       done ovf
        tbl[0]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 5'd1, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h0A, 1'b1, 1'b0, 1'b1, 8'h0A, 1'b0, 5'd1, 16'h0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 5'd1, 16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 5'd1, 16'h0000, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 16'h010F, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 5'd1, 16'h010F, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 5'd1, 16'h010F, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 5'd1, 16'h010F, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 5'd1, 16'h010F, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 16'h000A, 1'b0, 1'b0};

        reset_i     = 1'b0;
        res         = '0;
        res_valid   = 1'b0;
        m_ready     = 1'b0;
        clear       = 1'b0;
        b_res       = '0;
        b_res_valid = 1'b0;
        b_ready     = 1'b0;
        b_clear     = 1'b0;

        #3;
        chk_zero("reset");
        @(negedge clk);
        reset_i = 1'b1;

        // Streaming, latency and batch framing vectors
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rv, tbl[i].res, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("vec%0d valid", i), 32'(m_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("vec%0d data", i), 32'(m_data), 32'(tbl[i].ed));
            chk($sformatf("vec%0d last", i),  32'(m_last), 32'(tbl[i].el));
            chk($sformatf("vec%0d level", i), 32'(level), 32'(tbl[i].elev));
            chk($sformatf("vec%0d sum", i),   32'(batch_sum), 32'(tbl[i].esum));
            chk($sformatf("vec%0d done", i),  32'(batch_done), 32'(tbl[i].edone));
            chk($sformatf("vec%0d ovf", i),   32'(overflow), 32'(tbl[i].eovf));
        end

        // Fill without draining; the 17th item is dropped, head held stable
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            chk($sformatf("fill%0d level", i), 32'(level), (i < 16) ? 32'(i + 1) : 32'd16);
            chk($sformatf("fill%0d ovf", i), 32'(overflow), (i < 16) ? 32'd0 : 32'd1);
            chk($sformatf("fill%0d head", i), 32'(m_data), 32'd0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clear ovf", 32'(overflow), 0);
        chk("clear level", 32'(level), 16);

        // Full FIFO with simultaneous push and pop
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("fullpp level", 32'(level), 16);
        chk("fullpp ovf", 32'(overflow), 0);

        // Drain: remaining 1..15 then the item pushed while full
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("drain%0d data", k), 32'(m_data), (k < 16) ? 32'(k) : 32'hAA);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain level", 32'(level), 0);
        chk("drain valid", 32'(m_valid), 0);
        chk("drain sum", 32'(batch_sum), 32'h36);
        chk("drain done", 32'(batch_done), 0);

        // Mid-batch: AA already counted, 7 and 8 popped, 9 is the 4th beat
        step(1'b1, 8'h07, 1'b1, 1'b0);
        step(1'b1, 8'h08, 1'b1, 1'b0);
        step(1'b1, 8'h09, 1'b1, 1'b0);
        chk("midbatch last", 32'(m_last), 1);
        chk("midbatch data", 32'(m_data), 32'h09);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        reset_i = 1'b0;
        #1;
        chk_zero("async reset");
        @(negedge clk);
        reset_i = 1'b1;

        // After reset the batch count restarts at zero
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0);
            chk($sformatf("post%0d last", i), 32'(m_last), (i == 4) ? 32'd1 : 32'd0);
            chk($sformatf("post%0d data", i), 32'(m_data), 32'(i));
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post sum", 32'(batch_sum), 10);
        chk("post done", 32'(batch_done), 1);

        // Narrow checksum wraps modulo 2^8
        step_b(1'b1, 8'hFF, 1'b1, 1'b0);
        chk("b first last", 32'(b_last), 0);
        step_b(1'b1, 8'h02, 1'b1, 1'b0);
        chk("b second last", 32'(b_last), 1);
        step_b(1'b0, 8'h00, 1'b1, 1'b0);
        chk("b sum wrap", 32'(b_sum), 32'h01);
        chk("b done", 32'(b_done), 1);

        // Overflow on the narrow instance; drop wins over clear, then clear alone
        for (int i = 0; i < 17; i++) step_b(1'b1, 8'(i), 1'b0, 1'b0);
        chk("b ovf set", 32'(b_overflow), 1);
        chk("b level full", 32'(b_level), 16);
        step_b(1'b1, 8'h33, 1'b0, 1'b1);
        chk("b set beats clear", 32'(b_overflow), 1);
        step_b(1'b0, 8'h00, 1'b0, 1'b1);
        chk("b clear", 32'(b_overflow), 0);
        step_b(1'b0, 8'h00, 1'b0, 1'b0);
        chk("b clear stays", 32'(b_overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
